// File: rtl/flash_pkg.sv
// Shared state encoding, command codes and ID byte selection for the
// SPI-flash responder.
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  // ID bytes go out MSB byte first; anything past the third byte reads as zero.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      2'd2:    id_byte = id[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// Byte-wide synchronous read port between the responder (master) and its
// backing memory (slave). Read data is valid one cycle after mem_rd.
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_rd, output mem_addr, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser plus a history flop for one asynchronous SPI line;
// rise/fall are single-cycle pulses derived from the synchronised level.
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1_p0, s2_p1, s3_p2;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_p0 <= RST_VAL;
      s2_p1 <= RST_VAL;
      s3_p2 <= RST_VAL;
    end else begin
      s1_p0 <= pin;
      s2_p1 <= s1_p0;
      s3_p2 <= s2_p1;
    end
  end

  assign level = s2_p1;
  assign rise  = s2_p1 & ~s3_p2;
  assign fall  = ~s2_p1 & s3_p2;
endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI NOR-flash stand-in: serves READ, JEDEC ID and READ STATUS from a
// byte-wide synchronous memory, oversampling the SPI pins with clk_in.
module spi_flash_responder
  import flash_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  spi_flash_responder_if.master mem
);
  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_in_sync #(.RST_VAL(1'b0)) u_sck  (.clk_in(clk_in), .rst(rst), .pin(sck),
                                        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_in_sync #(.RST_VAL(1'b1)) u_cs   (.clk_in(clk_in), .rst(rst), .pin(cs_n),
                                        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_in_sync #(.RST_VAL(1'b0)) u_mosi (.clk_in(clk_in), .rst(rst), .pin(mosi),
                                        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_sync = ^{sck_lvl, cs_rise, mosi_rise, mosi_fall};

  state_e            state_q, state_d;
  logic [4:0]        in_cnt_q, in_cnt_d;
  logic [2:0]        out_cnt_q, out_cnt_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              started_q, started_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic              rd_issue, rd_pend_q;
  logic [22:0]       sh_in_q, sh_in_d;
  logic [7:0]        out_sr_q, out_sr_d, nxt_byte_q, src_byte;
  logic [23:0]       in_word;

  assign in_word = {sh_in_q, mosi_lvl};

  always_ff @(posedge clk_in) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    src_byte = 8'h00;
    case (state_q)
      ST_DATA: src_byte = nxt_byte_q;
      ST_ID:   src_byte = id_byte(JEDEC_ID, id_idx_q);
      ST_STAT: src_byte = STATUS;
      default: src_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    id_idx_d  = id_idx_q;
    started_d = started_q;
    addr_d    = addr_q;
    rd_issue  = 1'b0;
    rd_addr   = addr_q;
    sh_in_d   = sh_in_q;
    out_sr_d  = out_sr_q;
    case (state_q)
      ST_IDLE: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        id_idx_d  = '0;
        started_d = 1'b0;
        sh_in_d   = '0;
        out_sr_d  = '0;
        if (cs_fall) state_d = ST_CMD;
      end
      ST_CMD: if (sck_rise) begin
        sh_in_d  = in_word[22:0];
        in_cnt_d = in_cnt_q + 5'd1;
        if (in_cnt_q == 5'd7) begin
          in_cnt_d = '0;
          case (in_word[7:0])
            CMD_READ: state_d = ST_ADDR;
            CMD_RDID: state_d = ST_ID;
            CMD_RDSR: state_d = ST_STAT;
            default:  state_d = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: if (sck_rise) begin
        sh_in_d  = in_word[22:0];
        in_cnt_d = in_cnt_q + 5'd1;
        if (in_cnt_q == 5'd23) begin
          in_cnt_d = '0;
          rd_issue = 1'b1;
          rd_addr  = in_word[ADDR_W-1:0];
          addr_d   = rd_addr + ADDR_W'(1);
          state_d  = ST_DATA;
        end
      end
      // A byte boundary loads the next source byte; in DATA that load also
      // launches the single outstanding prefetch for the byte after it.
      ST_DATA, ST_ID, ST_STAT: if (sck_fall) begin
        out_cnt_d = out_cnt_q + 3'd1;
        if (out_cnt_q == 3'd0) begin
          out_sr_d  = src_byte;
          started_d = 1'b1;
          if (state_q == ST_DATA) begin
            rd_issue = 1'b1;
            addr_d   = addr_q + ADDR_W'(1);
          end
          if (state_q == ST_ID && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
        end else begin
          out_sr_d = {out_sr_q[6:0], 1'b0};
        end
      end
      default: ;
    endcase
    // Deselect aborts from any state and cancels a read launched this cycle.
    if (cs_lvl) begin
      state_d  = ST_IDLE;
      rd_issue = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      id_idx_q     <= '0;
      started_q    <= 1'b0;
      addr_q       <= '0;
      rd_pend_q    <= 1'b0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      id_idx_q   <= id_idx_d;
      started_q  <= started_d;
      addr_q     <= addr_d;
      rd_pend_q  <= mem.mem_rd;
      mem.mem_rd <= rd_issue;
      if (rd_issue) mem.mem_addr <= rd_addr;
      miso       <= started_q & out_sr_q[7];
      miso_oe    <= started_q;
      busy       <= ~cs_lvl;
    end
  end

  always_ff @(posedge clk_in) begin
    sh_in_q  <= sh_in_d;
    out_sr_q <= out_sr_d;
    if (rd_pend_q) nxt_byte_q <= mem.mem_data;
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a 24-bit and an 8-bit address
// instance share the SPI lines; returned bytes and reads go through queues.
module tb_spi_flash_responder;
  localparam int HALF = 8;

  logic clk_in = 1'b0;
  logic rst, sck, cs_n, mosi;
  logic miso_a, miso_oe_a, busy_a;
  logic miso_b, miso_oe_b, busy_b;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  logic [23:0] exp_rd_a[$];
  logic [7:0]  exp_rd_b[$];
  logic [23:0] obs_rd_a[$];
  logic [7:0]  obs_rd_b[$];

  logic       bit_a, bit_b, bit_oe;
  logic [7:0] rx_a, rx_b;
  logic       oe_all, oe_any;

  spi_flash_responder_if #(.ADDR_W(24)) bus_a ();
  spi_flash_responder_if #(.ADDR_W(8))  bus_b ();

  spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hEF4016), .STATUS(8'hA5)) dut_a (
    .clk_in(clk_in), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_a), .miso_oe(miso_oe_a), .busy(busy_a), .mem(bus_a));

  spi_flash_responder #(.ADDR_W(8), .JEDEC_ID(24'hEF4016), .STATUS(8'hA5)) dut_b (
    .clk_in(clk_in), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_b), .miso_oe(miso_oe_b), .busy(busy_b), .mem(bus_b));

  always #5 clk_in = ~clk_in;

  // Memory contents: location i holds i[7:0].
  always @(posedge clk_in) begin
    if (bus_a.mem_rd) bus_a.mem_data <= bus_a.mem_addr[7:0];
    if (bus_b.mem_rd) bus_b.mem_data <= bus_b.mem_addr;
  end

  always @(negedge clk_in) begin
    if (bus_a.mem_rd) obs_rd_a.push_back(bus_a.mem_addr);
    if (bus_b.mem_rd) obs_rd_b.push_back(bus_b.mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic spi_bit(input logic b);
    sck  = 1'b0;
    mosi = b;
    ticks(HALF);
    bit_a  = miso_a;
    bit_b  = miso_b;
    bit_oe = miso_oe_a;
    sck = 1'b1;
    ticks(HALF);
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i]);
      rx_a[i] = bit_a;
      rx_b[i] = bit_b;
      oe_all  = oe_all & bit_oe;
      oe_any  = oe_any | bit_oe;
    end
  endtask

  task automatic cs_begin();
    obs_rd_a.delete();
    obs_rd_b.delete();
    exp_rd_a.delete();
    exp_rd_b.delete();
    cs_n = 1'b0;
  endtask

  // Deselect with SCK still high so no trailing fall reaches a selected responder.
  task automatic cs_end();
    cs_n = 1'b1;
    ticks(4);
    sck = 1'b0;
    ticks(HALF);
  endtask

  task automatic recv(input string tag, input int n, input bit chk_b);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00);
      check({tag, "_byte_a"}, 32'(rx_a), 32'(exp_a.pop_front()));
      check({tag, "_oe_a"}, 32'(oe_all), 1);
      if (chk_b) check({tag, "_byte_b"}, 32'(rx_b), 32'(exp_b.pop_front()));
    end
  endtask

  task automatic check_reads(input string tag, input bit chk_b);
    check({tag, "_rd_cnt_a"}, obs_rd_a.size(), exp_rd_a.size());
    for (int k = 0; k < obs_rd_a.size() && k < exp_rd_a.size(); k++)
      check({tag, "_rd_addr_a"}, 32'(obs_rd_a[k]), 32'(exp_rd_a[k]));
    if (chk_b) begin
      check({tag, "_rd_cnt_b"}, obs_rd_b.size(), exp_rd_b.size());
      for (int k = 0; k < obs_rd_b.size() && k < exp_rd_b.size(); k++)
        check({tag, "_rd_addr_b"}, 32'(obs_rd_b[k]), 32'(exp_rd_b[k]));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    ticks(4);
    check("rst_miso", 32'(miso_a), 0);
    check("rst_miso_oe", 32'(miso_oe_a), 0);
    check("rst_mem_rd", 32'(bus_a.mem_rd), 0);
    check("rst_mem_addr", 32'(bus_a.mem_addr), 0);
    check("rst_busy", 32'(busy_a), 0);
    rst = 1'b0;
    ticks(4);

    // READ at 0x000010, four bytes plus one prefetch.
    cs_begin();
    ticks(4);
    check("busy_sel", 32'(busy_a), 1);
    for (int k = 0; k < 5; k++) exp_rd_a.push_back(24'(16 + k));
    for (int k = 0; k < 4; k++) exp_a.push_back(8'(16 + k));
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
    sck = 1'b0;
    ticks(5);
    check("first_bit_oe", 32'(miso_oe_a), 1);
    check("first_bit_val", 32'(miso_a), 0);
    recv("read", 4, 1'b0);
    cs_end();
    check_reads("read", 1'b0);
    check("busy_idle", 32'(busy_a), 0);

    // JEDEC ID.
    cs_begin();
    exp_a.push_back(8'hEF); exp_a.push_back(8'h40);
    exp_a.push_back(8'h16); exp_a.push_back(8'h00);
    spi_byte(8'h9F);
    recv("rdid", 4, 1'b0);
    cs_end();
    check_reads("rdid", 1'b1);

    // READ STATUS repeats the status byte, never touches memory.
    cs_begin();
    exp_a.push_back(8'hA5); exp_a.push_back(8'hA5);
    spi_byte(8'h05);
    recv("rdsr", 2, 1'b0);
    cs_end();
    check_reads("rdsr", 1'b1);

    // READ at 0xFFFFFF: the 8-bit instance wraps FF -> 00.
    cs_begin();
    exp_rd_a.push_back(24'hFFFFFF); exp_rd_a.push_back(24'h000000); exp_rd_a.push_back(24'h000001);
    exp_rd_b.push_back(8'hFF); exp_rd_b.push_back(8'h00); exp_rd_b.push_back(8'h01);
    exp_a.push_back(8'hFF); exp_a.push_back(8'h00);
    exp_b.push_back(8'hFF); exp_b.push_back(8'h00);
    spi_byte(8'h03); spi_byte(8'hFF); spi_byte(8'hFF); spi_byte(8'hFF);
    recv("wrap", 2, 1'b1);
    cs_end();
    check_reads("wrap", 1'b1);

    // Unknown command stays silent, the next select still works.
    cs_begin();
    spi_byte(8'h5A);
    spi_byte(8'hFF);
    check("unk_oe", 32'(oe_any), 0);
    cs_end();
    check_reads("unk", 1'b1);
    cs_begin();
    exp_a.push_back(8'hEF);
    spi_byte(8'h9F);
    recv("unk_rdid", 1, 1'b0);
    cs_end();

    // Deselect after 12 address bits.
    cs_begin();
    spi_byte(8'h03);
    spi_byte(8'h00);
    for (int k = 0; k < 4; k++) spi_bit(1'b1);
    cs_n = 1'b1;
    ticks(3);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_oe", 32'(miso_oe_a), 0);
    sck = 1'b0;
    ticks(HALF);
    check_reads("abort", 1'b1);
    cs_begin();
    exp_a.push_back(8'hA5);
    spi_byte(8'h05);
    recv("abort_rdsr", 1, 1'b0);
    cs_end();

    // Reset in the middle of a READ data byte.
    cs_begin();
    exp_a.push_back(8'h20);
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h20);
    recv("rst_data", 1, 1'b0);
    for (int k = 0; k < 3; k++) spi_bit(1'b0);
    check("pre_rst_oe", 32'(miso_oe_a), 1);
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    check("mid_rst_miso", 32'(miso_a), 0);
    check("mid_rst_miso_oe", 32'(miso_oe_a), 0);
    check("mid_rst_mem_rd", 32'(bus_a.mem_rd), 0);
    check("mid_rst_mem_addr", 32'(bus_a.mem_addr), 0);
    check("mid_rst_busy", 32'(busy_a), 0);
    cs_n = 1'b1;
    sck  = 1'b0;
    ticks(4);
    rst = 1'b0;
    ticks(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
